lea_decrypt_ctrl: RTL and testbench
===================================

LEA_DECRYPT_CTRL -- requirements
Module: lea_decrypt_ctrl

Interface
REQ-001 The block SHALL have parameter NROUNDS, default 24, giving the number of decryption rounds (24/28/32 for LEA-128/192/256).
REQ-002 The block SHALL have parameter AW, default 5, giving the round-key address width; NROUNDS SHALL be at most 2^AW.
REQ-003 Clk  input  1  single clock, all state updates on the rising edge.
REQ-004 Rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 Start  input  1  request to begin decryption of Din.
REQ-006 Din  input  128  ciphertext block, sampled on the edge where Start is accepted.
REQ-007 InReady  output  1  block idle; Start is accepted only when InReady=1.
REQ-008 RkAddr  output  AW  round-key memory address.
REQ-009 RkEn  output  1  round-key memory read enable.
REQ-010 RkData  input  192  round key returned by the external synchronous memory one cycle after it samples RkAddr with RkEn=1.
REQ-011 Dout  output  128  plaintext result.
REQ-012 DoutValid  output  1  Dout holds a completed result.
REQ-013 DoutReady  input  1  consumer accepts Dout.
REQ-014 Busy  output  1  high in LOAD, ROUND and DONE.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, ROUND and DONE.
REQ-016 IDLE -> LOAD on Start=1: the block SHALL register Din into the 128-bit state, set RkAddr=NROUNDS-1 and RkEn=1, and load RoundCnt=NROUNDS-1.
REQ-017 LOAD -> ROUND after exactly one cycle; this cycle is the memory read latency.
REQ-018 On each ROUND edge the state register SHALL take the value of one combinational LEA decryption round, using the current state as Din and RkData as RoundKey.
REQ-019 Round keys SHALL be consumed in descending order, RK[NROUNDS-1] first and RK[0] last.
REQ-020 While in ROUND with RoundCnt>0, RkAddr SHALL decrement by one on each edge.
REQ-021 RkEn SHALL deassert on the edge after address 0 is issued; RkAddr then SHALL hold 0.
REQ-022 ROUND -> DONE on the edge that applies the round at RoundCnt=0; on that same edge Dout SHALL take the final state and DoutValid SHALL rise.
REQ-023 Latency from the Start-accept edge to DoutValid rising SHALL be NROUNDS+1 edges (25 for the default), giving throughput of one round per cycle.
REQ-024 In DONE, Dout and DoutValid SHALL hold stable until DoutReady=1; on that edge the FSM SHALL go to IDLE and DoutValid SHALL fall.
REQ-025 Dout SHALL retain its last value after handoff.
REQ-026 InReady SHALL equal (state==IDLE), and Busy SHALL equal its inverse.
REQ-027 Start while not IDLE SHALL be ignored with no side effects, including in DONE on the same edge as DoutReady.
REQ-028 A Start held high across the DONE->IDLE transition SHALL be accepted on the following edge.
REQ-029 A DoutReady pulse outside DONE SHALL have no effect.
REQ-030 RoundCnt SHALL be AW bits and SHALL never wrap; it stops at 0.
REQ-031 The datapath is purely 32-bit modular: subtraction mod 2^32, XOR, rotates; the controller SHALL add no arithmetic.

Reset
REQ-032 On Rst_n=0 the block SHALL enter IDLE immediately, without waiting for a clock edge.
REQ-033 Reset values SHALL be: InReady=1, Busy=0, RkEn=0, RkAddr=0, DoutValid=0, Dout=0, state register=0, RoundCnt=0.
REQ-034 Reset asserted mid-operation, in LOAD, ROUND or DONE, SHALL abort the operation; no DoutValid SHALL follow.
REQ-035 The first Start accepted after reset release SHALL behave identically to one from power-up.
REQ-036 Deassertion of Rst_n is synchronised externally; the block need not handle a reset release coincident with Start.

Verification
REQ-037 KAT: memory loaded with the LEA-128 key schedule of key 0f1e2d3c4b5a69788796a5b4c3d2e1f0; Din = golden ciphertext of plaintext 101112131415161718191a1b1c1d1e1f (from the software model in the datapath's word order) -> Dout equals that plaintext, with DoutValid rising 25 edges after accept.
REQ-038 Key-order check: RkAddr sequence observed is 23, 22, ..., 0, each value held for one cycle; RkEn is high for exactly 24 cycles.
REQ-039 Backpressure: DoutReady held 0 for 10 cycles after DoutValid -> Dout stable and InReady=0 throughout; Start pulses in that window are ignored; DoutReady=1 -> IDLE on the next edge.
REQ-040 Back-to-back: Start held high continuously with DoutReady=1 for two blocks -> second accept occurs 2 edges after the first DoutValid; both results match the model.
REQ-041 Reset at round 12 -> all outputs at reset values asynchronously; a new block then decrypts correctly in 25 edges.
REQ-042 NROUNDS=32 (LEA-256 key schedule) -> RkAddr starts at 31, latency 33 edges, Dout matches the model.

Source files
------------

// File: rtl/lea_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
// lea_decrypt_ctrl : iterative LEA block decryption, one round per clock,
//                    round keys read in descending order from external sync RAM
// Revision 1.0
// ============================================================================
module lea_decrypt_ctrl #(
  parameter int NROUNDS = 24,
  parameter int AW      = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [127:0]  din_i,
  output logic          in_ready_o,
  output logic [AW-1:0] rk_addr_o,
  output logic          rk_en_o,
  input  logic [191:0]  rk_data_i,
  output logic [127:0]  dout_o,
  output logic          dout_valid_o,
  input  logic          dout_ready_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [AW-1:0] C_LAST = AW'(NROUNDS - 1);

  state_e        fsm_q, fsm_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  dout_q, dout_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;

  logic [31:0]   w_r0, w_r1, w_r2;
  logic [31:0]   w_x0, w_x1, w_x2, w_x3;
  logic [127:0]  w_round;

  // Inverse round: undo the rotations, then peel off the keyed additions
  // in order, each stage depending on the word recovered before it.
  assign w_r0 = {st_q[8:0],   st_q[31:9]};
  assign w_r1 = {st_q[58:32], st_q[63:59]};
  assign w_r2 = {st_q[92:64], st_q[95:93]};
  assign w_x0 = st_q[127:96];
  assign w_x1 = (w_r0 - (w_x0 ^ rk_data_i[31:0]))    ^ rk_data_i[63:32];
  assign w_x2 = (w_r1 - (w_x1 ^ rk_data_i[95:64]))   ^ rk_data_i[127:96];
  assign w_x3 = (w_r2 - (w_x2 ^ rk_data_i[159:128])) ^ rk_data_i[191:160];
  assign w_round = {w_x3, w_x2, w_x1, w_x0};

  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    dout_d = dout_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d  = LOAD;
          st_d   = din_i;
          addr_d = C_LAST;
          cnt_d  = C_LAST;
          en_d   = 1'b1;
        end
      end
      LOAD, ROUND: begin
        // Address runs one step ahead of the round being applied.
        if (addr_q != '0) begin
          addr_d = addr_q - 1'b1;
        end else begin
          en_d = 1'b0;
        end
        if (fsm_q == LOAD) begin
          fsm_d = ROUND;
        end else begin
          st_d = w_round;
          if (cnt_q == '0) begin
            fsm_d  = DONE;
            dout_d = w_round;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        if (dout_ready_i) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      dout_q <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      dout_q <= dout_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
    end
  end

  assign in_ready_o   = (fsm_q == IDLE);
  assign busy_o       = (fsm_q != IDLE);
  assign dout_valid_o = (fsm_q == DONE);
  assign dout_o       = dout_q;
  assign rk_addr_o    = addr_q;
  assign rk_en_o      = en_q;

endmodule
`default_nettype wire

// File: tb/tb_lea_decrypt_ctrl.sv
`default_nettype none
// Bench for lea_decrypt_ctrl: 24- and 32-round instances, ciphertexts from an
// encryption-side LEA model, expected plaintexts held in scoreboard queues.
module tb_lea_decrypt_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_start, a_in_ready, a_rk_en, a_valid, a_ready, a_busy;
  logic [127:0] a_din, a_dout;
  logic [4:0]   a_addr;
  logic [191:0] a_rk_data;
  logic         b_start, b_in_ready, b_rk_en, b_valid, b_ready, b_busy;
  logic [127:0] b_din, b_dout;
  logic [4:0]   b_addr;
  logic [191:0] b_rk_data;

  logic [191:0] a_mem [32];
  logic [191:0] b_mem [32];
  logic [127:0] a_q [$];
  logic [127:0] b_q [$];
  int checks = 0;
  int errors = 0;

  lea_decrypt_ctrl #(.NROUNDS(24), .AW(5)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .din_i(a_din),
    .in_ready_o(a_in_ready), .rk_addr_o(a_addr), .rk_en_o(a_rk_en),
    .rk_data_i(a_rk_data), .dout_o(a_dout), .dout_valid_o(a_valid),
    .dout_ready_i(a_ready), .busy_o(a_busy)
  );

  lea_decrypt_ctrl #(.NROUNDS(32), .AW(5)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .din_i(b_din),
    .in_ready_o(b_in_ready), .rk_addr_o(b_addr), .rk_en_o(b_rk_en),
    .rk_data_i(b_rk_data), .dout_o(b_dout), .dout_valid_o(b_valid),
    .dout_ready_i(b_ready), .busy_o(b_busy)
  );

  always @(posedge clk) begin
    if (a_rk_en) a_rk_data <= a_mem[a_addr];
    if (b_rk_en) b_rk_data <= b_mem[b_addr];
  end

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  // Byte string (first byte in the MSBs) to little-endian words, word0 in [31:0].
  function automatic logic [127:0] bytes_to_words(input logic [127:0] b);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = b[127-8*i -: 8];
    return w;
  endfunction

  function automatic logic [127:0] lea_enc(input logic [127:0] p, input bit wide);
    logic [31:0] x0, x1, x2, x3, n0, n1, n2;
    logic [191:0] k;
    int nr;
    nr = wide ? 32 : 24;
    {x3, x2, x1, x0} = p;
    for (int i = 0; i < nr; i++) begin
      k  = wide ? b_mem[i] : a_mem[i];
      n0 = rol((x0 ^ k[31:0])    + (x1 ^ k[63:32]),   9);
      n1 = rol((x1 ^ k[95:64])   + (x2 ^ k[127:96]),  27);
      n2 = rol((x2 ^ k[159:128]) + (x3 ^ k[191:160]), 29);
      x3 = x0; x0 = n0; x1 = n1; x2 = n2;
    end
    return {x3, x2, x1, x0};
  endfunction

  task automatic build_keys();
    logic [31:0]  dl [8];
    logic [31:0]  t [8];
    logic [127:0] k;
    int           rot [6];
    int           ix;
    dl = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
           32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957};
    rot = '{1, 3, 6, 11, 13, 17};
    for (int i = 0; i < 32; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    k = bytes_to_words(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
    for (int i = 0; i < 24; i++) begin
      t[0] = rol(t[0] + rol(dl[i%4], i),     1);
      t[1] = rol(t[1] + rol(dl[i%4], i + 1), 3);
      t[2] = rol(t[2] + rol(dl[i%4], i + 2), 6);
      t[3] = rol(t[3] + rol(dl[i%4], i + 3), 11);
      a_mem[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
    end
    k = bytes_to_words(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
    k = bytes_to_words(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
    for (int j = 0; j < 4; j++) t[4+j] = k[32*j +: 32];
    for (int i = 0; i < 32; i++) begin
      for (int m = 0; m < 6; m++) begin
        ix = (6*i + m) % 8;
        t[ix] = rol(t[ix] + rol(dl[i%8], i + m), rot[m]);
      end
      for (int m = 0; m < 6; m++) b_mem[i][32*m +: 32] = t[(6*i + m) % 8];
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_a(input logic [127:0] pt);
    @(negedge clk);
    a_din = lea_enc(pt, 1'b0);
    a_start = 1'b1;
    a_q.push_back(pt);
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_valid(input bit wide, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if ((wide ? b_valid : a_valid) == 1'b1) begin n = i; break; end
    end
  endtask

  task automatic handoff_a();
    @(negedge clk); a_ready = 1'b1;
    @(posedge clk); #1; a_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
    checks++; if (a_rk_en !== 1'b0) begin errors++; $display("FAIL reset_rk_en got %b want 0", a_rk_en); end
    checks++; if (a_addr !== 5'd0) begin errors++; $display("FAIL reset_rk_addr got %0d want 0", a_addr); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
    checks++; if (a_dout !== 128'd0) begin errors++; $display("FAIL reset_dout got %h want 0", a_dout); end
    checks++; if ({b_in_ready, b_busy, b_rk_en, b_valid} !== 4'b1000 || b_addr !== 5'd0) begin
      errors++; $display("FAIL reset_dut32 got rdy/busy/en/vld=%b addr=%0d want 1000 addr=0",
                         {b_in_ready, b_busy, b_rk_en, b_valid}, b_addr);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_kat();
    logic [127:0] pt, exp;
    int n;
    pt = bytes_to_words(128'h101112131415161718191a1b1c1d1e1f);
    start_a(pt);
    wait_valid(1'b0, n);
    exp = a_q.pop_front();
    checks++; if (n != 25) begin errors++; $display("FAIL kat_latency got %0d want 25", n); end
    checks++; if (a_dout !== exp) begin errors++; $display("FAIL kat_dout got %h want %h", a_dout, exp); end
    handoff_a();
    checks++; if (a_in_ready !== 1'b1 || a_valid !== 1'b0) begin
      errors++; $display("FAIL kat_handoff got rdy=%b vld=%b want rdy=1 vld=0", a_in_ready, a_valid);
    end
  endtask

  task automatic test_key_order();
    logic [127:0] exp;
    int idx, vedge;
    idx = 0; vedge = -1;
    start_a(rand128());
    // sampling point k is just after accept edge + k
    for (int k = 0; k < 40; k++) begin
      if (a_rk_en) begin
        checks++; if (a_addr !== 5'(23 - idx)) begin errors++; $display("FAIL key_addr[%0d] got %0d want %0d", idx, a_addr, 23 - idx); end
        idx++;
      end
      if (a_valid) begin vedge = k; break; end
      if (k == 10) a_ready = 1'b1;
      if (k == 11) a_ready = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (idx != 24) begin errors++; $display("FAIL key_en_cycles got %0d want 24", idx); end
    checks++; if (vedge != 25) begin errors++; $display("FAIL key_latency got %0d want 25", vedge); end
    checks++; if (a_addr !== 5'd0 || a_rk_en !== 1'b0) begin errors++; $display("FAIL key_addr_hold got addr=%0d en=%b want 0/0", a_addr, a_rk_en); end
    exp = a_q.pop_front();
    checks++; if (a_dout !== exp) begin errors++; $display("FAIL key_dout got %h want %h", a_dout, exp); end
    handoff_a();
  endtask

  task automatic test_backpressure();
    logic [127:0] exp;
    int n;
    start_a(rand128());
    wait_valid(1'b0, n);
    exp = a_q.pop_front();
    checks++; if (n != 25) begin errors++; $display("FAIL bp_latency got %0d want 25", n); end
    for (int c = 0; c < 11; c++) begin
      checks++; if (a_dout !== exp || a_in_ready !== 1'b0 || a_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got dout=%h rdy=%b vld=%b want dout=%h rdy=0 vld=1", c, a_dout, a_in_ready, a_valid, exp);
      end
      if (c == 10) break;
      @(negedge clk); a_start = (c % 2 == 0); a_din = rand128();
      @(posedge clk); #1; a_start = 1'b0;
    end
    // Start together with DoutReady: must leave DONE without starting anything
    @(negedge clk); a_start = 1'b1; a_ready = 1'b1;
    @(posedge clk); #1; a_start = 1'b0; a_ready = 1'b0;
    checks++; if (a_in_ready !== 1'b1 || a_valid !== 1'b0 || a_dout !== exp) begin
      errors++; $display("FAIL bp_release got rdy=%b vld=%b dout=%h want rdy=1 vld=0 dout=%h", a_in_ready, a_valid, a_dout, exp);
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1 || a_rk_en !== 1'b0) begin
      errors++; $display("FAIL bp_no_side_effect got rdy=%b en=%b want 1/0", a_in_ready, a_rk_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] p1, p2, exp;
    int n, m;
    p1 = rand128(); p2 = rand128();
    @(negedge clk);
    a_ready = 1'b1; a_start = 1'b1; a_din = lea_enc(p1, 1'b0);
    a_q.push_back(p1); a_q.push_back(p2);
    @(posedge clk); #1; a_din = lea_enc(p2, 1'b0);
    wait_valid(1'b0, n);
    exp = a_q.pop_front();
    checks++; if (n != 25) begin errors++; $display("FAIL b2b_latency1 got %0d want 25", n); end
    checks++; if (a_dout !== exp) begin errors++; $display("FAIL b2b_dout1 got %h want %h", a_dout, exp); end
    m = -1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (a_in_ready == 1'b0) begin m = i; break; end
    end
    a_start = 1'b0;
    checks++; if (m != 2) begin errors++; $display("FAIL b2b_second_accept got %0d want 2", m); end
    wait_valid(1'b0, n);
    exp = a_q.pop_front();
    checks++; if (n != 25) begin errors++; $display("FAIL b2b_latency2 got %0d want 25", n); end
    checks++; if (a_dout !== exp) begin errors++; $display("FAIL b2b_dout2 got %h want %h", a_dout, exp); end
    @(posedge clk); #1; a_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [127:0] exp;
    int n, bad;
    start_a(rand128());
    repeat (12) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    checks++; if ({a_in_ready, a_busy, a_rk_en, a_valid} !== 4'b1000 || a_addr !== 5'd0 || a_dout !== 128'd0) begin
      errors++; $display("FAIL abort_async got rdy/busy/en/vld=%b addr=%0d dout=%h want 1000 addr=0 dout=0",
                         {a_in_ready, a_busy, a_rk_en, a_valid}, a_addr, a_dout);
    end
    a_q.delete();
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (30) begin @(posedge clk); #1; if (a_valid) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_no_valid got %0d want 0", bad); end
    start_a(rand128());
    wait_valid(1'b0, n);
    exp = a_q.pop_front();
    checks++; if (n != 25) begin errors++; $display("FAIL abort_latency got %0d want 25", n); end
    checks++; if (a_dout !== exp) begin errors++; $display("FAIL abort_dout got %h want %h", a_dout, exp); end
    handoff_a();
  endtask

  task automatic test_nr32();
    logic [127:0] pt, exp;
    int n;
    pt = rand128();
    @(negedge clk);
    b_din = lea_enc(pt, 1'b1); b_start = 1'b1; b_q.push_back(pt);
    @(posedge clk); #1; b_start = 1'b0;
    checks++; if (b_addr !== 5'd31 || b_rk_en !== 1'b1) begin errors++; $display("FAIL nr32_first_addr got %0d en=%b want 31 en=1", b_addr, b_rk_en); end
    wait_valid(1'b1, n);
    exp = b_q.pop_front();
    checks++; if (n != 33) begin errors++; $display("FAIL nr32_latency got %0d want 33", n); end
    checks++; if (b_dout !== exp) begin errors++; $display("FAIL nr32_dout got %h want %h", b_dout, exp); end
    @(negedge clk); b_ready = 1'b1;
    @(posedge clk); #1; b_ready = 1'b0;
    checks++; if (b_in_ready !== 1'b1 || b_busy !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("FAIL nr32_handoff got rdy=%b busy=%b vld=%b want 1/0/0", b_in_ready, b_busy, b_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_ready = 1'b0; a_din = '0;
    b_start = 1'b0; b_ready = 1'b0; b_din = '0;
    build_keys();
    test_reset();
    test_kat();
    test_key_order();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_nr32();
    checks++; if (a_q.size() != 0 || b_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d/%0d want 0/0", a_q.size(), b_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
